// File: rtl/operand_sequencer_pkg.sv
// Shared state codes and default widths for the operand sequencer and its
// pad synchroniser.
package operand_sequencer_pkg;

  localparam int DATA_W     = 8;
  localparam int SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GOT_A   = 2'b01,
    ST_PRESENT = 2'b10
  } state_t;

endpackage

// File: rtl/operand_sequencer_pad_sync.sv
// Multi-bit flop-chain synchroniser for pad signals. All bits travel through
// the same depth so a bus and its strobe stay aligned.
module pad_sync
  import operand_sequencer_pkg::*;
#(
  parameter int WIDTH  = DATA_W + 1,
  parameter int STAGES = SYNC_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/operand_sequencer.sv
// Captures two operands from an asynchronous pad bus on successive strobe
// edges and presents them to the compute stage with a valid/ready handshake.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int WIDTH       = DATA_W,
  parameter int SYNC_STAGES = SYNC_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             strobe,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [1:0]       state,
  output logic             overrun
);

  logic [WIDTH:0]   sync_bus;
  logic [WIDTH-1:0] sync_din;
  logic             sync_strobe;
  logic             strobe_prev;
  logic             edge_det;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_d, op_b_d;
  logic             op_valid_d, overrun_d;

  pad_sync #(
    .WIDTH  (WIDTH + 1),
    .STAGES (SYNC_STAGES)
  ) u_pad_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({strobe, din}),
    .q     (sync_bus)
  );

  assign sync_strobe = sync_bus[WIDTH];
  assign sync_din    = sync_bus[WIDTH-1:0];
  assign edge_det    = sync_strobe & ~strobe_prev;

  // strobe_prev tracks regardless of ena so re-enabling never sees a stale edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) strobe_prev <= 1'b0;
    else        strobe_prev <= sync_strobe;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_a     <= '0;
      op_b     <= '0;
      op_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a     <= op_a_d;
      op_b     <= op_b_d;
      op_valid <= op_valid_d;
      overrun  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a;
    op_b_d     = op_b;
    op_valid_d = op_valid;
    overrun_d  = overrun;

    if (clear) begin
      state_d    = ST_IDLE;
      op_a_d     = '0;
      op_b_d     = '0;
      op_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ena && edge_det) begin
            op_a_d  = sync_din;
            state_d = ST_GOT_A;
          end
        end
        ST_GOT_A: begin
          if (ena && edge_det) begin
            op_b_d     = sync_din;
            op_valid_d = 1'b1;
            state_d    = ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          // A transfer coinciding with an edge starts the next pair at once
          if (ena && op_ready) begin
            op_valid_d = 1'b0;
            if (edge_det) begin
              op_a_d  = sync_din;
              state_d = ST_GOT_A;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (ena && edge_det) begin
            overrun_d = 1'b1;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          op_valid_d = 1'b0;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed self-checking bench for operand_sequencer, with a second instance
// at SYNC_STAGES=3 for the latency check.
module tb_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       clear;
  logic [7:0] din;
  logic       strobe;
  logic       op_ready;

  logic [7:0] op_a, op_b;
  logic       op_valid, overrun;
  logic [1:0] state;

  logic [7:0] op_a3, op_b3;
  logic       op_valid3, overrun3;
  logic [1:0] state3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  operand_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .clear    (clear),
    .din      (din),
    .strobe   (strobe),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .state    (state),
    .overrun  (overrun)
  );

  operand_sequencer #(.WIDTH(8), .SYNC_STAGES(3)) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .clear    (clear),
    .din      (din),
    .strobe   (strobe),
    .op_a     (op_a3),
    .op_b     (op_b3),
    .op_valid (op_valid3),
    .op_ready (op_ready),
    .state    (state3),
    .overrun  (overrun3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // one-cycle strobe pulse, then wait until the 2-stage capture is visible
  task automatic applyStimulus(input logic [7:0] data);
    din    = data;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst_n    = 1'b1;
    ena      = 1'b1;
    clear    = 1'b0;
    din      = 8'h00;
    strobe   = 1'b0;
    op_ready = 1'b0;

    #2 rst_n = 1'b0;
    tick();
    checkOutput("rst_op_a", op_a, 8'h00);
    checkOutput("rst_op_b", op_b, 8'h00);
    checkOutput("rst_valid", op_valid, 8'h00);
    checkOutput("rst_state", state, 8'h00);
    checkOutput("rst_overrun", overrun, 8'h00);
    #3 rst_n = 1'b1;
    tick();
    tick();

    // basic pair with ready held high
    op_ready = 1'b1;
    applyStimulus(8'h3C);
    checkOutput("p1_state_gota", state, 8'h01);
    checkOutput("p1_op_a", op_a, 8'h3C);
    checkOutput("p1_valid_low", op_valid, 8'h00);
    applyStimulus(8'hA5);
    checkOutput("p1_state_present", state, 8'h02);
    checkOutput("p1_valid_high", op_valid, 8'h01);
    checkOutput("p1_op_b", op_b, 8'hA5);
    tick();
    checkOutput("p1_valid_one_cycle", op_valid, 8'h00);
    checkOutput("p1_state_idle", state, 8'h00);
    checkOutput("p1_op_a_hold", op_a, 8'h3C);
    checkOutput("p1_op_b_hold", op_b, 8'hA5);
    checkOutput("p1_overrun", overrun, 8'h00);

    // overrun while presenting
    op_ready = 1'b0;
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    checkOutput("ov_present", state, 8'h02);
    applyStimulus(8'h33);
    checkOutput("ov_op_a", op_a, 8'h11);
    checkOutput("ov_op_b", op_b, 8'h22);
    checkOutput("ov_valid", op_valid, 8'h01);
    checkOutput("ov_state", state, 8'h02);
    checkOutput("ov_flag", overrun, 8'h01);
    tick();
    checkOutput("ov_sticky", overrun, 8'h01);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("clr_overrun", overrun, 8'h00);
    checkOutput("clr_state", state, 8'h00);
    checkOutput("clr_valid", op_valid, 8'h00);
    checkOutput("clr_op_a", op_a, 8'h00);

    // transfer and edge in the same cycle
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    checkOutput("te_present", state, 8'h02);
    din    = 8'h44;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    checkOutput("te_op_a", op_a, 8'h44);
    checkOutput("te_op_b_hold", op_b, 8'h02);
    checkOutput("te_state", state, 8'h01);
    checkOutput("te_valid", op_valid, 8'h00);
    checkOutput("te_overrun", overrun, 8'h00);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // disabled captures and no stale edge on re-enable
    ena = 1'b0;
    applyStimulus(8'h55);
    applyStimulus(8'h66);
    checkOutput("dis_state", state, 8'h00);
    checkOutput("dis_op_a", op_a, 8'h00);
    din    = 8'h5A;
    strobe = 1'b1;
    tick();
    tick();
    tick();
    ena = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("reen_state", state, 8'h00);
    checkOutput("reen_op_a", op_a, 8'h00);
    strobe = 1'b0;
    tick();
    tick();
    tick();
    tick();

    // asynchronous reset mid-operation
    applyStimulus(8'h77);
    checkOutput("ar_gota", state, 8'h01);
    checkOutput("ar_op_a_pre", op_a, 8'h77);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_op_a", op_a, 8'h00);
    checkOutput("ar_state", state, 8'h00);
    checkOutput("ar_valid", op_valid, 8'h00);
    #3 rst_n = 1'b1;
    tick();
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    checkOutput("ar2_op_a", op_a, 8'h01);
    checkOutput("ar2_op_b", op_b, 8'h02);
    checkOutput("ar2_valid", op_valid, 8'h01);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    checkOutput("ar2_idle", state, 8'h00);

    // three-stage latency, plus an unsampled glitch
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    tick();
    tick();
    tick();
    checkOutput("l3_idle", state3, 8'h00);
    din    = 8'h99;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
    tick();
    checkOutput("l2_op_a", op_a, 8'h99);
    checkOutput("l3_not_yet", op_a3, 8'h00);
    checkOutput("l3_state_not_yet", state3, 8'h00);
    tick();
    checkOutput("l3_op_a", op_a3, 8'h99);
    checkOutput("l3_state", state3, 8'h01);
    din    = 8'hEE;
    strobe = 1'b1;
    #3 strobe = 1'b0;
    tick();
    tick();
    tick();
    tick();
    tick();
    checkOutput("gl3_state", state3, 8'h01);
    checkOutput("gl3_op_b", op_b3, 8'h00);
    checkOutput("gl2_state", state, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
